// File: rtl/i2c_bit_counter.sv
// ---------------------------------------------------------------------------
// i2c_bit_counter
//
// Bit/byte counter for the I2C datapath. A start strobe arms a run with a
// terminal count; each tick from the bit engine advances the count. When the
// terminal tick arrives, a one-cycle done pulse follows and the completed-run
// counter (bytes) increments. With reload=1 at the terminal tick the run
// restarts immediately, which supports multi-byte bursts.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous reset, active low
//   start   arm pulse: load target, clear count and bytes, enter COUNT
//   tick    one-cycle bit strobe, only counted while in COUNT
//   abort   cancel the run and return to IDLE, count/bytes hold, no done
//   reload  sampled at the terminal tick: 1 = restart run, 0 = stop
//   tc_in   terminal count, sampled on an accepted start (0 -> DEFAULT_TC)
//   count   bits counted in the current run
//   bytes   completed runs since the last start (wraps)
//   busy    high while in COUNT
//   done    one-cycle pulse in the cycle after a terminal tick
// ---------------------------------------------------------------------------
module i2c_bit_counter #(
  parameter int WIDTH      = 4,
  parameter int DEFAULT_TC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             tick,
  input  logic             abort,
  input  logic             reload,
  input  logic [WIDTH-1:0] tc_in,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] bytes,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] DEF_TC = WIDTH'(DEFAULT_TC);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] target_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] bytes_nxt;
  logic             done_nxt;
  logic             terminal;

  // busy comes straight off the state register, so it changes in the same
  // cycle as the state (it drops together with the done pulse).
  assign busy = (state == COUNT);

  // The target is never zero (a zero request is replaced by DEFAULT_TC), so
  // target-1 cannot underflow and the count can never run past the target.
  assign terminal = (count == (target - 1'b1));

  // State and datapath registers; everything resets asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      target <= DEF_TC;
      count  <= '0;
      bytes  <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      target <= target_nxt;
      count  <= count_nxt;
      bytes  <= bytes_nxt;
      done   <= done_nxt;
    end
  end

  // Next-state logic. Priority is abort, then start, then tick: a start
  // always swallows a same-cycle tick, which is what suppresses done when a
  // restart collides with a terminal tick.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    count_nxt  = count;
    bytes_nxt  = bytes;
    done_nxt   = 1'b0;

    if (abort) begin
      state_nxt = IDLE;
    end else if (start) begin
      target_nxt = (tc_in == '0) ? DEF_TC : tc_in;
      count_nxt  = '0;
      bytes_nxt  = '0;
      state_nxt  = COUNT;
    end else if (tick && (state == COUNT)) begin
      if (terminal) begin
        done_nxt  = 1'b1;
        bytes_nxt = bytes + 1'b1;
        if (reload) begin
          count_nxt = '0;
        end else begin
          // Leave the full count visible until the next start.
          count_nxt = target;
          state_nxt = IDLE;
        end
      end else begin
        count_nxt = count + 1'b1;
      end
    end
  end

endmodule
